// File: rtl/aes_pkg.sv
// Shared AES key-expansion definitions: round count, round-constant table
// and controller state encoding.
package aes_pkg;

  localparam int unsigned NR = 10;

  // Indexed by round number; entry 0 and entries past round 10 are unused.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERROR
  } kx_state_e;

endpackage

// File: rtl/round_key_store.sv
// Round-key register file: one synchronous write port, one combinational
// read port; addresses at or beyond DEPTH read as zero.
module round_key_store #(
  parameter int unsigned KEY_L = 128,
  parameter int unsigned DEPTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [KEY_L-1:0] wr_data,
  input  logic [3:0]       rd_addr,
  output logic [KEY_L-1:0] rd_data
);

  logic [KEY_L-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (32'(rd_addr) < DEPTH) begin
      rd_data = mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/key_expansion_ctrl.sv
// Key-expansion sequencer: issues one request per round to an external
// round-key generator, collects results into the round-key store.
module key_expansion_ctrl #(
  parameter int unsigned KEY_L   = 128,
  parameter int unsigned WORD    = 32,
  parameter int unsigned NR      = aes_pkg::NR,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_L-1:0] key_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             gen_valid_in,
  output logic [KEY_L-1:0] gen_key,
  output logic [WORD-1:0]  gen_rcon,
  input  logic             gen_valid_out,
  input  logic [KEY_L-1:0] gen_round_key,
  input  logic [3:0]       rk_addr,
  output logic [KEY_L-1:0] rk_data
);

  import aes_pkg::*;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  kx_state_e        state_q, state_d;
  logic [3:0]       round_q;
  logic [CW-1:0]    wait_cnt_q;
  logic             load_start;
  logic             accept;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [KEY_L-1:0] wr_data;

  function automatic logic [WORD-1:0] rcon_word(input logic [3:0] r);
    return {RCON[r], {(WORD - 8){1'b0}}};
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    gen_valid_in = 1'b0;
    load_start   = 1'b0;
    accept       = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = round_q;
    wr_data      = gen_round_key;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        done = (state_q == DONE);
        err  = (state_q == ERROR);
        if (start) begin
          load_start = 1'b1;
          wr_en      = 1'b1;
          wr_addr    = '0;
          wr_data    = key_in;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        busy         = 1'b1;
        gen_valid_in = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        // A response on the last allowed cycle still wins over the timeout.
        if (gen_valid_out) begin
          accept  = 1'b1;
          wr_en   = 1'b1;
          state_d = (round_q == 4'(NR)) ? DONE : ISSUE;
        end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ERROR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // gen_key/gen_rcon are loaded on the way into ISSUE so they are already
  // valid during the issue cycle and stay put through WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_q    <= '0;
      wait_cnt_q <= '0;
      gen_key    <= '0;
      gen_rcon   <= '0;
    end else begin
      wait_cnt_q <= (state_q == WAIT) ? wait_cnt_q + CW'(1) : '0;
      if (load_start) begin
        round_q  <= 4'd1;
        gen_key  <= key_in;
        gen_rcon <= rcon_word(4'd1);
      end else if (accept && (round_q != 4'(NR))) begin
        round_q  <= round_q + 4'd1;
        gen_key  <= gen_round_key;
        gen_rcon <= rcon_word(round_q + 4'd1);
      end
    end
  end

  round_key_store #(
    .KEY_L(KEY_L),
    .DEPTH(NR + 1)
  ) u_store (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rk_addr),
    .rd_data(rk_data)
  );

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Bench for key_expansion_ctrl: AES-128 round-key generator stub with
// configurable latency, plus a key-schedule reference model.
`timescale 1ns/1ps
module tb_key_expansion_ctrl;

  localparam int unsigned KEY_L   = 128;
  localparam int unsigned WORD    = 32;
  localparam int unsigned NR      = 10;
  localparam int unsigned TIMEOUT = 31;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [KEY_L-1:0] key_in;
  logic             busy, done, err;
  logic             gen_valid_in;
  logic [KEY_L-1:0] gen_key;
  logic [WORD-1:0]  gen_rcon;
  logic             gen_valid_out;
  logic [KEY_L-1:0] gen_round_key;
  logic [3:0]       rk_addr;
  logic [KEY_L-1:0] rk_data;

  key_expansion_ctrl #(
    .KEY_L  (KEY_L),
    .WORD   (WORD),
    .NR     (NR),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_in       (key_in),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .gen_valid_in (gen_valid_in),
    .gen_key      (gen_key),
    .gen_rcon     (gen_rcon),
    .gen_valid_out(gen_valid_out),
    .gen_round_key(gen_round_key),
    .rk_addr      (rk_addr),
    .rk_data      (rk_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned  addr;
    logic [127:0] exp;
  } rd_vec_t;

  int unsigned  n_checks;
  int unsigned  n_fail;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [0:10];
  logic [31:0]  exp_rcon [1:10];

  // stub controls, written by the main sequence only
  bit           gen_mute;
  bit           rand_lat;
  int unsigned  fixed_lat;
  int unsigned  spur_req;
  // written by the stub only
  int unsigned  lat_log [$];
  int unsigned  stab_err;
  // written by the monitor only
  int unsigned  pulse_cnt;
  logic [31:0]  rcon_log [$];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_rk(input logic [127:0] p, input logic [31:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = p;
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ rc;
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [7:0] rc;
    rc = 8'h01;
    exp_rk[0] = key;
    for (int r = 1; r <= 10; r++) begin
      exp_rcon[r] = {rc, 24'h0};
      exp_rk[r]   = next_rk(exp_rk[r-1], exp_rcon[r]);
      rc          = xtime(rc);
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Generator stub: answers each issue after a chosen latency and flags any
  // change of gen_key/gen_rcon while the request is outstanding.
  initial begin : gen_stub
    logic [127:0] k;
    logic [31:0]  r;
    int unsigned  lat;
    int unsigned  spur_done;
    spur_done     = 0;
    gen_valid_out = 1'b0;
    gen_round_key = '0;
    forever begin
      @(negedge clk);
      gen_valid_out = 1'b0;
      if (spur_req != spur_done) begin
        spur_done     = spur_req;
        gen_valid_out = 1'b1;
        gen_round_key = {$urandom, $urandom, $urandom, $urandom};
      end else if (gen_valid_in && !gen_mute) begin
        k   = gen_key;
        r   = gen_rcon;
        lat = rand_lat ? $urandom_range(12, 1) : fixed_lat;
        lat_log.push_back(lat);
        for (int unsigned i = 0; i < lat; i++) begin
          @(negedge clk);
          if (reset && (gen_key !== k || gen_rcon !== r)) stab_err++;
        end
        gen_valid_out = 1'b1;
        gen_round_key = next_rk(k, r);
      end
    end
  end

  always @(negedge clk) begin
    if (gen_valid_in) begin
      pulse_cnt++;
      rcon_log.push_back(gen_rcon);
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_end(input int unsigned limit, output int unsigned cyc);
    cyc = 0;
    while (!done && !err && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic read_rk(input int unsigned a, output logic [127:0] v);
    rk_addr = 4'(a);
    #1 v = rk_data;
  endtask

  // Waits until round n is outstanding in WAIT; returns 0 on expiry.
  task automatic wait_round(input int unsigned base, input int unsigned n, output bit found);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk);
      #1;
      if ((pulse_cnt - base) == n && busy && !gen_valid_in) found = 1'b1;
    end
  endtask

  initial begin : main
    rd_vec_t      tbl [6];
    logic [127:0] v, key_a;
    int unsigned  cyc, base, lbase, sbase, expc;
    bit           found;

    gen_mute  = 1'b0;
    rand_lat  = 1'b0;
    fixed_lat = 4;
    spur_req  = 0;
    build_sbox();

    reset   = 1'b0;
    start   = 1'b0;
    key_in  = '0;
    rk_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_err", 128'(err), 128'(0));
    check("rst_gen_valid_in", 128'(gen_valid_in), 128'(0));
    check("rst_gen_key", gen_key, '0);
    check("rst_gen_rcon", 128'(gen_rcon), '0);
    reset = 1'b1;
    @(negedge clk);
    for (int unsigned a = 0; a < 16; a++) begin
      read_rk(a, v);
      check($sformatf("rst_rk[%0d]", a), v, '0);
    end

    // Known-answer expansion with a fixed 4-cycle generator.
    model_expand(FIPS_KEY);
    base  = pulse_cnt;
    lbase = rcon_log.size();
    sbase = stab_err;
    do_start(FIPS_KEY);
    wait_end(400, cyc);
    check("fips_done", 128'(done), 128'(1));
    check("fips_busy", 128'(busy), 128'(0));
    check("fips_err", 128'(err), 128'(0));
    check("fips_cycles", 128'(cyc), 128'(10 * (4 + 1)));
    check("fips_pulses", 128'(pulse_cnt - base), 128'(10));
    check("fips_key_stable", 128'(stab_err - sbase), 128'(0));
    for (int r = 1; r <= 10; r++) begin
      v = (rcon_log.size() > lbase + r - 1) ? 128'(rcon_log[lbase + r - 1]) : 'x;
      check($sformatf("fips_rcon[%0d]", r), v, 128'(exp_rcon[r]));
    end
    tbl[0] = '{0,  FIPS_KEY};
    tbl[1] = '{1,  FIPS_RK1};
    tbl[2] = '{10, FIPS_RK10};
    tbl[3] = '{5,  exp_rk[5]};
    tbl[4] = '{11, 128'h0};
    tbl[5] = '{15, 128'h0};
    for (int i = 0; i < 6; i++) begin
      read_rk(tbl[i].addr, v);
      check($sformatf("fips_rk[%0d]", tbl[i].addr), v, tbl[i].exp);
    end

    // Random keys with random per-round generator latency.
    rand_lat = 1'b1;
    for (int it = 0; it < 4; it++) begin
      key_a = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key_a);
      lbase = lat_log.size();
      do_start(key_a);
      wait_end(600, cyc);
      expc = 0;
      for (int r = 0; r < 10; r++) begin
        expc += (lat_log.size() > lbase + r) ? lat_log[lbase + r] + 1 : 1000;
      end
      check($sformatf("rand%0d_done", it), 128'(done), 128'(1));
      check($sformatf("rand%0d_cycles", it), 128'(cyc), 128'(expc));
      for (int unsigned a = 0; a <= 10; a++) begin
        read_rk(a, v);
        check($sformatf("rand%0d_rk[%0d]", it, a), v, exp_rk[a]);
      end
    end
    rand_lat = 1'b0;

    // Longest latency that must still be accepted.
    fixed_lat = TIMEOUT;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_a);
    do_start(key_a);
    wait_end(1000, cyc);
    check("lat31_done", 128'(done), 128'(1));
    check("lat31_err", 128'(err), 128'(0));
    check("lat31_cycles", 128'(cyc), 128'(10 * (TIMEOUT + 1)));
    read_rk(10, v);
    check("lat31_rk[10]", v, exp_rk[10]);

    // start pulsed while waiting in round 5 must be ignored.
    fixed_lat = 4;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_a);
    base = pulse_cnt;
    do_start(key_a);
    wait_round(base, 5, found);
    check("ign_reach_round5", 128'(found), 128'(1));
    do_start(~key_a);
    check("ign_still_busy", 128'(busy), 128'(1));
    wait_end(400, cyc);
    check("ign_done", 128'(done), 128'(1));
    check("ign_pulses", 128'(pulse_cnt - base), 128'(10));
    read_rk(0, v);
    check("ign_rk[0]", v, key_a);
    read_rk(10, v);
    check("ign_rk[10]", v, exp_rk[10]);

    // Generator that never answers.
    gen_mute = 1'b1;
    base = pulse_cnt;
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_end(100, cyc);
    check("to_err", 128'(err), 128'(1));
    check("to_cycles", 128'(cyc), 128'(TIMEOUT + 1));
    check("to_busy", 128'(busy), 128'(0));
    check("to_done", 128'(done), 128'(0));
    check("to_pulses", 128'(pulse_cnt - base), 128'(1));
    gen_mute  = 1'b0;
    fixed_lat = 2;
    key_a = {$urandom, $urandom, $urandom, $urandom};
    model_expand(key_a);
    do_start(key_a);
    check("to_restart_err", 128'(err), 128'(0));
    check("to_restart_busy", 128'(busy), 128'(1));
    wait_end(400, cyc);
    check("to_restart_done", 128'(done), 128'(1));
    read_rk(10, v);
    check("to_restart_rk[10]", v, exp_rk[10]);

    // Reset in round 3; the pending and a spurious response land in IDLE.
    fixed_lat = 4;
    base = pulse_cnt;
    do_start({$urandom, $urandom, $urandom, $urandom});
    wait_round(base, 3, found);
    check("rst3_reach_round3", 128'(found), 128'(1));
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("rst3_busy_async", 128'(busy), 128'(0));
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    spur_req = spur_req + 1;
    repeat (12) @(negedge clk);
    check("rst3_busy", 128'(busy), 128'(0));
    check("rst3_done", 128'(done), 128'(0));
    check("rst3_err", 128'(err), 128'(0));
    check("rst3_gen_key", gen_key, '0);
    for (int unsigned a = 0; a <= 10; a++) begin
      read_rk(a, v);
      check($sformatf("rst3_rk[%0d]", a), v, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_expansion_ctrl.md
KEY_EXPANSION_CTRL -- requirements
Module: key_expansion_ctrl

Interface
REQ-001 SHALL have parameter KEY_L, default 128, key and round-key width.
REQ-002 SHALL have parameter WORD, default 32, word width.
REQ-003 SHALL have parameter NR, default 10, number of generated round keys.
REQ-004 SHALL have parameter TIMEOUT, default 31, maximum cycles waited per round for generator response.
REQ-005 SHALL have ports: clk  input  1  system clock; reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: start  input  1  begin expansion; key_in  input  KEY_L  cipher key, sampled with start.
REQ-007 SHALL have ports: busy  output  1  expansion in progress; done  output  1  all NR keys stored; err  output  1  generator timeout.
REQ-008 SHALL have ports: gen_valid_in  output  1  one-cycle issue strobe to generator; gen_key  output  KEY_L  previous round key; gen_rcon  output  WORD  round constant.
REQ-009 SHALL have ports: gen_valid_out  input  1  generator result valid; gen_round_key  input  KEY_L  generator result.
REQ-010 SHALL have ports: rk_addr  input  4  round-key index 0..NR; rk_data  output  KEY_L  stored round key, combinational read.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, DONE, ERROR.
REQ-012 IDLE/DONE/ERROR with start=1: SHALL write key_in to store[0], set round counter to 1, clear done/err, go to ISSUE next cycle.
REQ-013 ISSUE: SHALL assert gen_valid_in for exactly one cycle, with gen_key=store[round-1] and gen_rcon={RCON[round],24'h0}, then go to WAIT.
REQ-014 gen_key and gen_rcon SHALL be held stable from ISSUE until the cycle gen_valid_out is accepted.
REQ-015 RCON[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-016 WAIT with gen_valid_out=1: SHALL write gen_round_key to store[round]; if round==NR, go to DONE, else increment round and go to ISSUE.
REQ-017 Per-round latency SHALL be independent of the generator depth: exactly one ISSUE cycle plus the observed wait, with no added bubble.
REQ-018 WAIT SHALL count cycles; if TIMEOUT cycles elapse without gen_valid_out, SHALL go to ERROR with err=1.
REQ-019 busy SHALL be 1 in ISSUE and WAIT only; done SHALL be 1 in DONE only; err SHALL be 1 in ERROR only.
REQ-020 start while busy SHALL be ignored.
REQ-021 gen_valid_out outside WAIT SHALL be ignored, with no store write.
REQ-022 rk_addr > NR SHALL return zero; store contents SHALL remain readable in every state until overwritten by the next start.

Reset
REQ-023 reset low SHALL force IDLE, round=0, timeout counter=0, busy=0, done=0, err=0, gen_valid_in=0, gen_key=0, gen_rcon=0, and all store entries=0.
REQ-024 reset asserted mid-expansion SHALL abort without any further store write; a late gen_valid_out after reset release SHALL be ignored per REQ-021.

Structure
REQ-025 NR, the RCON table, and the state enumeration SHALL reside in shared package aes_pkg.
REQ-026 The (NR+1) x KEY_L register file with one write port and one combinational read port SHALL be sub-module round_key_store.

Verification
REQ-027 Connect the generator. Apply key_in=2b7e151628aed2a6abf7158809cf4f3c with start. Required: rk[1]=a0fafe1788542cb123a339392a6c7605 and rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-028 Use a stub generator with 4-cycle latency. Required: exactly 10 gen_valid_in pulses; gen_rcon sequence 01000000 through 36000000; done asserted.
REQ-029 Assert start during WAIT at round 5. Required: it is ignored, and rk[0] is unchanged at the end.
REQ-030 Use a stub that never responds. Required: err=1 after 31 WAIT cycles and busy=0; a subsequent start clears err.
REQ-031 Assert reset during round 3, then release it and inject a spurious gen_valid_out. Required: state is IDLE, all rk=0, done=0.
REQ-032 Drive rk_addr=11 and rk_addr=15. Required: rk_data=0.
